// File: rtl/adpll_ctr_seq_pkg.sv
// Shared constants and types for the ADPLL control sequencer.
// Register map, mode codes and sequencer state encoding.
package adpll_ctr_seq_pkg;

  localparam int FCWW         = 26;
  localparam int ADPLL_ADDR_W = 4;
  localparam int ADPLL_DATA_W = 32;

  localparam logic [ADPLL_ADDR_W-1:0] A_FCW  = 4'd0;
  localparam logic [ADPLL_ADDR_W-1:0] A_MODE = 4'd1;
  localparam logic [ADPLL_ADDR_W-1:0] A_EN   = 4'd2;
  localparam logic [ADPLL_ADDR_W-1:0] A_LOCK = 4'd3;

  localparam logic [1:0] MODE_TX = 2'd1;
  localparam logic [1:0] MODE_RX = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_FCW  = 4'd1,
    S_WR_MODE = 4'd2,
    S_WR_EN   = 4'd3,
    S_RD_LOCK = 4'd4,
    S_GAP     = 4'd5,
    S_LOCKED  = 4'd6,
    S_ERR     = 4'd7,
    S_WR_DIS  = 4'd8
  } state_t;

endpackage

// File: rtl/adpll_tx_ser.sv
// TX byte serialiser: MSB-first shifter, per-bit timer and
// valid/ready handshake producing the data_mod bit.
module adpll_tx_ser #(
  parameter int BIT_CYCLES = 32,
  parameter int TX_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic [TX_W-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_bit
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int IW = (TX_W > 1) ? $clog2(TX_W) : 1;

  logic            r_full;
  logic [TX_W-1:0] r_sh;
  logic [CW-1:0]   r_cyc;
  logic [IW-1:0]   r_idx;
  logic            w_bit_end;
  logic            w_last;
  logic            w_acc;

  assign w_bit_end = r_cyc == CW'(BIT_CYCLES - 1);
  assign w_last    = w_bit_end && (r_idx == IW'(TX_W - 1));
  // Ready in the final clock of a byte lets the next one follow gaplessly
  assign o_ready   = i_en && (!r_full || w_last);
  assign w_acc     = i_valid && o_ready;
  assign o_bit     = i_en && r_full && r_sh[TX_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_sh   <= '0;
      r_cyc  <= '0;
      r_idx  <= '0;
    end else if (!i_en) begin
      r_full <= 1'b0;
      r_sh   <= '0;
      r_cyc  <= '0;
      r_idx  <= '0;
    end else if (w_acc) begin
      r_full <= 1'b1;
      r_sh   <= i_data;
      r_cyc  <= '0;
      r_idx  <= '0;
    end else if (r_full) begin
      if (w_bit_end) begin
        r_cyc <= '0;
        r_sh  <= r_sh << 1;
        if (w_last) begin
          r_full <= 1'b0;
          r_idx  <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_cyc <= r_cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adpll_ctr_seq.sv
// ADPLL control sequencer: configures FCW/mode/enable over the CPU
// port, polls for lock, then streams TX bytes onto data_mod.
module adpll_ctr_seq
  import adpll_ctr_seq_pkg::*;
#(
  parameter int BIT_CYCLES   = 32,
  parameter int POLL_GAP     = 8,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int TX_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [FCWW-1:0]         fcw,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    locked,
  output logic                    lock_err,
  input  logic [TX_W-1:0]         tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic                    valid,
  output logic [ADPLL_ADDR_W-1:0] address,
  output logic [ADPLL_DATA_W-1:0] wdata,
  output logic                    wstrb,
  input  logic [1:0]              rdata,
  input  logic                    ready,
  output logic                    data_mod
);

  localparam int PCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);

  state_t                  r_st;
  state_t                  w_nx;
  logic                    r_valid;
  logic [ADPLL_ADDR_W-1:0] r_addr;
  logic [ADPLL_DATA_W-1:0] r_wdata;
  logic                    r_wstrb;
  logic [FCWW-1:0]         r_fcw;
  logic [1:0]              r_mode;
  logic                    r_stop;
  logic [PCW-1:0]          r_polls;
  logic [GCW-1:0]          r_gap;

  logic                    w_done;
  logic                    w_stop;
  logic                    w_start_ok;
  logic                    w_last_poll;
  logic                    w_is_bus;
  logic                    w_pend_st;
  logic [ADPLL_ADDR_W-1:0] w_req_addr;
  logic [ADPLL_DATA_W-1:0] w_req_data;
  logic                    w_req_wr;
  logic                    w_tx_en;

  assign w_done      = r_valid && ready;
  assign w_stop      = stop || r_stop;
  assign w_start_ok  = start && !stop &&
                       (r_st == S_IDLE || r_st == S_ERR);
  assign w_last_poll = r_polls == PCW'(LOCK_TIMEOUT - 1);
  assign w_pend_st   = r_st inside {S_WR_FCW, S_WR_MODE,
                                    S_WR_EN, S_RD_LOCK, S_GAP};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_IDLE;
    else        r_st <= w_nx;
  end

  always_comb begin
    w_nx = r_st;
    unique case (r_st)
      S_IDLE:    if (w_start_ok) w_nx = S_WR_FCW;
      S_WR_FCW:  if (w_done) w_nx = w_stop ? S_WR_DIS : S_WR_MODE;
      S_WR_MODE: if (w_done) w_nx = w_stop ? S_WR_DIS : S_WR_EN;
      S_WR_EN:   if (w_done) w_nx = w_stop ? S_WR_DIS : S_RD_LOCK;
      S_RD_LOCK: begin
        if (w_done) begin
          if (w_stop)              w_nx = S_WR_DIS;
          else if (rdata == 2'd1)  w_nx = S_LOCKED;
          else if (w_last_poll)    w_nx = S_ERR;
          else                     w_nx = S_GAP;
        end
      end
      S_GAP: begin
        if (w_stop)                             w_nx = S_WR_DIS;
        else if (r_gap == GCW'(POLL_GAP - 1))   w_nx = S_RD_LOCK;
      end
      S_LOCKED:  if (stop) w_nx = S_WR_DIS;
      S_ERR: begin
        if (stop)            w_nx = S_WR_DIS;
        else if (w_start_ok) w_nx = S_WR_FCW;
      end
      S_WR_DIS:  if (w_done) w_nx = S_IDLE;
      default:   w_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_is_bus   = 1'b1;
    w_req_addr = '0;
    w_req_data = '0;
    w_req_wr   = 1'b0;
    unique case (1'b1)
      r_st == S_WR_FCW: begin
        w_req_addr = A_FCW;
        w_req_data = ADPLL_DATA_W'(r_fcw);
        w_req_wr   = 1'b1;
      end
      r_st == S_WR_MODE: begin
        w_req_addr = A_MODE;
        w_req_data = ADPLL_DATA_W'(r_mode);
        w_req_wr   = 1'b1;
      end
      r_st == S_WR_EN: begin
        w_req_addr = A_EN;
        w_req_data = ADPLL_DATA_W'(1);
        w_req_wr   = 1'b1;
      end
      r_st == S_RD_LOCK: w_req_addr = A_LOCK;
      r_st == S_WR_DIS: begin
        w_req_addr = A_EN;
        w_req_wr   = 1'b1;
      end
      default: w_is_bus = 1'b0;
    endcase
  end

  // A request is raised one clock after entering a bus state,
  // which gives the mandatory idle cycle between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= 1'b0;
      r_fcw   <= '0;
      r_mode  <= '0;
      r_stop  <= 1'b0;
      r_polls <= '0;
      r_gap   <= '0;
    end else begin
      if (w_done) begin
        r_valid <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_wstrb <= 1'b0;
      end else if (w_is_bus && !r_valid) begin
        r_valid <= 1'b1;
        r_addr  <= w_req_addr;
        r_wdata <= w_req_data;
        r_wstrb <= w_req_wr;
      end
      if (w_start_ok) begin
        r_fcw   <= fcw;
        r_mode  <= mode;
        r_polls <= '0;
      end else if (r_st == S_RD_LOCK && w_done) begin
        r_polls <= r_polls + 1'b1;
      end
      if (!w_pend_st || w_nx == S_WR_DIS) r_stop <= 1'b0;
      else if (stop)                      r_stop <= 1'b1;
      if (r_st == S_GAP) r_gap <= r_gap + 1'b1;
      else               r_gap <= '0;
    end
  end

  assign valid    = r_valid;
  assign address  = r_addr;
  assign wdata    = r_wdata;
  assign wstrb    = r_wstrb;
  assign busy     = !(r_st inside {S_IDLE, S_LOCKED, S_ERR});
  assign locked   = r_st == S_LOCKED;
  assign lock_err = r_st == S_ERR;
  assign w_tx_en  = (r_st == S_LOCKED) && (r_mode == MODE_TX);

  adpll_tx_ser #(
    .BIT_CYCLES(BIT_CYCLES),
    .TX_W      (TX_W)
  ) u_tx_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_tx_en),
    .i_data (tx_data),
    .i_valid(tx_valid),
    .o_ready(tx_ready),
    .o_bit  (data_mod)
  );

endmodule

// File: tb/tb_adpll_ctr_seq.sv
// Directed bench for adpll_ctr_seq with a bus responder model
// that logs every ADPLL transaction and emulates the lock bit.
module tb_adpll_ctr_seq;
  import adpll_ctr_seq_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    stop = 1'b0;
  logic [FCWW-1:0]         fcw = '0;
  logic [1:0]              mode = '0;
  logic                    busy, locked, lock_err;
  logic [7:0]              tx_data = '0;
  logic                    tx_valid = 1'b0;
  logic                    tx_ready;
  logic                    valid;
  logic [ADPLL_ADDR_W-1:0] address;
  logic [ADPLL_DATA_W-1:0] wdata;
  logic                    wstrb;
  logic [1:0]              rdata = '0;
  logic                    ready = 1'b0;
  logic                    data_mod;

  always #5 clk = ~clk;

  adpll_ctr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .fcw(fcw), .mode(mode), .busy(busy), .locked(locked),
    .lock_err(lock_err), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .data_mod(data_mod)
  );

  int n_chk = 0;
  int n_err = 0;
  int lat = 0;
  int lock_after = 0;
  int rd_cnt = 0;
  int ncyc = 0;
  int wcnt = 0;
  bit vprev = 0;
  bit unstable = 0;
  logic [ADPLL_ADDR_W-1:0] h_a;
  logic [ADPLL_DATA_W-1:0] h_d;
  logic                    h_s;
  int                      q_start[$];
  int                      q_ack[$];
  logic [ADPLL_ADDR_W-1:0] q_addr[$];
  logic [ADPLL_DATA_W-1:0] q_data[$];
  logic                    q_wr[$];

  // Bus responder: acks after lat clocks, logs, models ADPLL_LOCK
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      ready = 1'b0; rdata = '0; wcnt = 0; vprev = 0;
    end else begin
      if (valid && vprev && (address !== h_a || wdata !== h_d || wstrb !== h_s))
        unstable = 1;
      if (valid && !vprev) begin
        q_start.push_back(ncyc);
        h_a = address; h_d = wdata; h_s = wstrb; wcnt = 0;
      end
      vprev = valid;
      if (ready) begin
        ready = 1'b0; rdata = '0;
      end else if (valid) begin
        if (wcnt >= lat) begin
          ready = 1'b1;
          rdata = '0;
          if (address == A_LOCK && !wstrb) begin
            if (lock_after >= 0 && rd_cnt >= lock_after) rdata = 2'd1;
            rd_cnt++;
          end
          q_ack.push_back(ncyc);
          q_addr.push_back(address);
          q_data.push_back(wdata);
          q_wr.push_back(wstrb);
        end else begin
          wcnt++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    repeat (2) @(negedge clk);
    q_start.delete(); q_ack.delete(); q_addr.delete();
    q_data.delete(); q_wr.delete();
    unstable = 0; rd_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [FCWW-1:0] f);
    fcw = f; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_locked(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (locked) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bit found;
    do_reset();
    n_chk++;
    if ({valid, busy, locked, lock_err, tx_ready, data_mod, wstrb} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_outs got %b exp 0000000",
               {valid, busy, locked, lock_err, tx_ready, data_mod, wstrb});
    end
    n_chk++;
    if ({address, wdata} !== '0) begin
      n_err++; $display("FAIL rst_bus got %h/%h exp 0/0", address, wdata);
    end
    pulse_stop();
    repeat (5) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || q_addr.size() != 0) begin
      n_err++; $display("FAIL idle_stop busy=%b txns=%0d exp 0/0", busy, q_addr.size());
    end
    lat = 20; lock_after = 0;
    pulse_start(MODE_TX, 26'd123);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (valid && address == A_MODE) begin found = 1; break; end
      @(negedge clk);
    end
    n_chk++;
    if (!found) begin n_err++; $display("FAIL rst_reach_mode got 0 exp 1"); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({valid, busy, data_mod} !== 3'b000) begin
      n_err++; $display("FAIL async_rst got %b exp 000", {valid, busy, data_mod});
    end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_config;
    bit ok;
    logic [ADPLL_ADDR_W-1:0] ea[3];
    logic [ADPLL_DATA_W-1:0] ed[3];
    ea[0] = A_FCW;  ed[0] = 32'd39976960;
    ea[1] = A_MODE; ed[1] = 32'(MODE_TX);
    ea[2] = A_EN;   ed[2] = 32'd1;
    do_reset();
    lat = 3; lock_after = 0;
    pulse_start(MODE_TX, 26'(2440 * 16384));
    wait_locked(200, ok);
    n_chk++;
    if (!ok || q_addr.size() != 4) begin
      n_err++; $display("FAIL cfg_lock ok=%0d txns=%0d exp 1/4", ok, q_addr.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (q_addr.size() < 4 || q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_wr[i] !== 1'b1) begin
        n_err++;
        $display("FAIL cfg_wr%0d got a=%0d d=%0d exp a=%0d d=%0d", i,
                 q_addr.size() > i ? q_addr[i] : 4'hF,
                 q_data.size() > i ? q_data[i] : 32'hFFFFFFFF, ea[i], ed[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (q_ack.size() < 4 || q_ack[i] - q_start[i] != 3 || q_start[i+1] - q_ack[i] != 2) begin
        n_err++; $display("FAIL cfg_timing%0d hold/gap wrong exp hold 3 gap 2", i);
      end
    end
    n_chk++;
    if (unstable) begin n_err++; $display("FAIL cfg_stable got unstable exp stable"); end
    n_chk++;
    if (busy !== 1'b0 || locked !== 1'b1) begin
      n_err++; $display("FAIL cfg_state busy=%b locked=%b exp 0/1", busy, locked);
    end
  endtask

  task automatic test_poll;
    bit ok;
    bit bad;
    do_reset();
    lat = 0; lock_after = 5;
    pulse_start(MODE_TX, 26'd1000);
    wait_locked(1000, ok);
    n_chk++;
    if (!ok || rd_cnt != 6 || q_addr.size() != 9) begin
      n_err++; $display("FAIL poll_count ok=%0d reads=%0d exp 1/6", ok, rd_cnt);
    end
    bad = 0;
    for (int i = 3; i < 9 && i < q_addr.size(); i++)
      if (q_addr[i] !== A_LOCK || q_wr[i] !== 1'b0) bad = 1;
    n_chk++;
    if (bad) begin n_err++; $display("FAIL poll_kind got non-read exp LOCK reads"); end
    bad = 0;
    for (int i = 3; i < 8 && i + 1 < q_start.size(); i++)
      if (q_start[i+1] - q_ack[i] - 1 < 8) bad = 1;
    n_chk++;
    if (bad) begin n_err++; $display("FAIL poll_gap got <8 idle exp >=8"); end
    n_chk++;
    if (locked !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL poll_locked locked=%b busy=%b exp 1/0", locked, busy);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n0;
    do_reset();
    lat = 0; lock_after = -1;
    pulse_start(MODE_TX, 26'd1);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (lock_err) begin ok = 1; break; end
      @(negedge clk);
    end
    n_chk++;
    if (!ok || rd_cnt != 1024) begin
      n_err++; $display("FAIL to_reads ok=%0d reads=%0d exp 1/1024", ok, rd_cnt);
    end
    n_chk++;
    if ({lock_err, busy, locked} !== 3'b100) begin
      n_err++; $display("FAIL to_flags got %b exp 100", {lock_err, busy, locked});
    end
    n0 = q_addr.size();
    repeat (50) @(negedge clk);
    n_chk++;
    if (q_addr.size() != n0 || valid !== 1'b0) begin
      n_err++; $display("FAIL to_quiet txns=%0d exp %0d", q_addr.size(), n0);
    end
    pulse_stop();
    repeat (20) @(negedge clk);
    n_chk++;
    if (q_addr.size() != n0 + 1 || q_addr[n0] !== A_EN || q_data[n0] !== '0 || q_wr[n0] !== 1'b1) begin
      n_err++; $display("FAIL to_dis txns=%0d exp %0d with EN=0 write", q_addr.size(), n0 + 1);
    end
    n_chk++;
    if ({lock_err, busy} !== 2'b00) begin
      n_err++; $display("FAIL to_idle got %b exp 00", {lock_err, busy});
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit pend;
    int first_rdy;
    int errs;
    logic samp[512];
    logic [15:0] pat;
    pat = 16'hA53C;
    do_reset();
    lat = 0; lock_after = 0;
    pulse_start(MODE_TX, 26'd77);
    wait_locked(200, ok);
    n_chk++;
    if (!ok || tx_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready ok=%0d tx_ready=%b exp 1/1", ok, tx_ready);
    end
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    pend = 0; first_rdy = -1;
    for (int i = 0; i < 512; i++) begin
      if (pend) tx_valid = 1'b0;
      samp[i] = data_mod;
      if (tx_ready && first_rdy < 0) first_rdy = i;
      if (tx_ready && tx_valid) pend = 1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    for (int b = 0; b < 16; b++) begin
      errs = 0;
      for (int k = 0; k < 32; k++)
        if (samp[b*32 + k] !== pat[15 - b]) errs++;
      n_chk++;
      if (errs != 0) begin
        n_err++; $display("FAIL b2b_bit%0d got %0d bad clks exp value %b", b, errs, pat[15 - b]);
      end
    end
    n_chk++;
    if (first_rdy != 255) begin
      n_err++; $display("FAIL b2b_rdy_at got %0d exp 255", first_rdy);
    end
    n_chk++;
    if (data_mod !== 1'b0 || tx_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_end data_mod=%b tx_ready=%b exp 0/1", data_mod, tx_ready);
    end
  endtask

  task automatic test_stop;
    bit ok;
    bit seen;
    int n0;
    tx_data = 8'hFF; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (40) @(negedge clk);
    n_chk++;
    if (data_mod !== 1'b1) begin n_err++; $display("FAIL stop_mid got %b exp 1", data_mod); end
    n0 = q_addr.size();
    pulse_stop();
    n_chk++;
    if ({data_mod, busy, tx_ready} !== 3'b010) begin
      n_err++; $display("FAIL stop_abort got %b exp 010", {data_mod, busy, tx_ready});
    end
    repeat (10) @(negedge clk);
    n_chk++;
    if (q_addr.size() != n0 + 1 || q_addr[n0] !== A_EN || q_data[n0] !== '0) begin
      n_err++; $display("FAIL stop_dis txns=%0d exp %0d with EN=0", q_addr.size(), n0 + 1);
    end
    n_chk++;
    if ({busy, locked} !== 2'b00) begin
      n_err++; $display("FAIL stop_idle got %b exp 00", {busy, locked});
    end
    pulse_start(MODE_RX, 26'd5);
    wait_locked(200, ok);
    n_chk++;
    if (!ok || q_data[n0 + 2] !== 32'(MODE_RX)) begin
      n_err++; $display("FAIL rx_lock ok=%0d mode=%0d exp 1/%0d", ok, q_data[n0 + 2], MODE_RX);
    end
    tx_data = 8'hFF; tx_valid = 1'b1;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_ready || data_mod) seen = 1;
    end
    tx_valid = 1'b0;
    n_chk++;
    if (seen) begin n_err++; $display("FAIL rx_no_tx got activity exp none"); end
  endtask

  task automatic test_stop_sticky;
    bit found;
    do_reset();
    lat = 10; lock_after = 0;
    pulse_start(MODE_TX, 26'd9);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid) begin found = 1; break; end
      @(negedge clk);
    end
    pulse_stop();
    repeat (40) @(negedge clk);
    n_chk++;
    if (!found || q_addr.size() != 2 || q_addr[0] !== A_FCW || q_ack[0] - q_start[0] != 10) begin
      n_err++; $display("FAIL sticky_fcw txns=%0d exp FCW completed then 1 more", q_addr.size());
    end
    n_chk++;
    if (q_addr.size() < 2 || q_addr[1] !== A_EN || q_data[1] !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL sticky_dis busy=%b exp EN=0 write then idle", busy);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_poll();
    test_timeout();
    test_back_to_back();
    test_stop();
    test_stop_sticky();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
